gfau_arbiter: RTL
=================

Name: gfau_arbiter

Overview:
Round-robin arbiter and sequencer that shares one GFAU instance (add/sub/mult/div over GF(p)) between N_REQ independent requesters, e.g. point-add and point-double controllers of the ECC core. Per request it accepts one operation, issues a single-cycle start to the GFAU and holds operands stable. It then waits for GFAU completion and returns the result to the owning requester. A watchdog aborts operations that never complete.

Parameters:
N_REQ, 4, number of requesters (2..8)
SIZE, 33, operand/result width, matches GFAU
TIMEOUT, 1023, max cycles in WAIT before abort (must fit TW bits)
TW, 10, watchdog counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request
req_ready  out  N_REQ  one-hot accept; combinational, high only in IDLE for the granted requester
req_op  in  2*N_REQ  per-requester op: 0 add, 1 sub, 2 mult, 3 div
req_a  in  SIZE*N_REQ  per-requester operand 0
req_b  in  SIZE*N_REQ  per-requester operand 1
rsp_valid  out  N_REQ  one-hot single-cycle response strobe
rsp_data  out  SIZE  result, valid while any rsp_valid bit is high
rsp_err  out  1  timeout flag, qualified by rsp_valid
busy  out  1  high in every state except IDLE
gfau_in_0  out  SIZE  to GFAU in_0
gfau_in_1  out  SIZE  to GFAU in_1
gfau_op  out  2  to GFAU operation_select
gfau_start  out  1  to GFAU done_from_control
gfau_result  in  SIZE  from GFAU result
gfau_done  in  1  from GFAU done_to_control

Behaviour:
- Reset (i_rst_n low, async): state IDLE, rr pointer 0, all outputs 0, operand/op/owner/result registers 0, watchdog 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first set req_valid bit, searching from the rr pointer upward with wrap. req_ready[grant] = 1 in the same cycle. On accept (valid & ready), latch owner, op, a, b; next state ISSUE. No valid request: remain in IDLE.
- ISSUE: gfau_start = 1 for exactly this one cycle; watchdog cleared; next state WAIT.
- gfau_in_0, gfau_in_1 and gfau_op are driven from the latched registers from ISSUE through RESP inclusive. They never change mid-operation, because mult scans operand bits serially.
- WAIT: watchdog increments each cycle.
  - gfau_done = 1: capture gfau_result, err = 0, next state RESP.
  - Watchdog == TIMEOUT with gfau_done = 0: result = 0, err = 1, next state RESP.
  - gfau_done and timeout in the same cycle: gfau_done wins.
- Completion is the first gfau_done in WAIT. gfau_done seen in IDLE or ISSUE is stale and ignored.
- RESP: rsp_valid[owner] = 1 for one cycle, with rsp_data and rsp_err driven from the registers. rr pointer becomes (owner+1) mod N_REQ. Next state IDLE.
- Minimum occupancy is accept + ISSUE + GFAU latency + RESP. The earliest next accept is the cycle after RESP.
- gfau_start is a pulse, never a level, so the GFAU add/sub units fire only once.
- Requesters hold req_* stable until ready. Deasserting req_valid before accept is legal; the arbiter re-evaluates every IDLE cycle.
- Reset asserted mid-operation: immediate return to IDLE, no response emitted. The GFAU is reset by the same reset.
- prime is not routed through this block.

Decomposition:
- Shared package gfau_pkg: op encoding constants (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3), SIZE, and FSM state encoding.
- One sub-module, rr_pick: combinational round-robin priority selector (inputs: request vector, pointer; outputs: one-hot grant, index).
- The watchdog and FSM stay in gfau_arbiter.

Test Plan:
1. Real GFAU, prime=23. Requester 1 issues add a=20 b=5. Expect req_ready[1] in the accept cycle, gfau_start one cycle later, then rsp_valid=4'b0010 with rsp_data=2 and rsp_err=0.
2. Real GFAU, prime=23. Requester 0 issues sub a=3 b=5 -> rsp_data=21. Check that gfau_in_0/1 and gfau_op are constant from ISSUE through RESP.
3. Round-robin: after reset, req_valid=4'b0101 held -> grants 0, 2, 0, 2. Then with the last grant at 2, req_valid=4'b0111 -> next grant is 0, then 1.
4. Timeout: stub GFAU never raises done, TIMEOUT=15. Expect rsp_valid 16 cycles after gfau_start with rsp_err=1 and rsp_data=0. The next request is then accepted normally.
5. Stale done: stub pulses gfau_done in IDLE and in ISSUE. Expect these to be ignored; the response is taken from the later WAIT pulse only, and the done/timeout tie resolves to success.
6. Reset: drop i_rst_n during WAIT. Expect all outputs to go to 0 immediately, no rsp_valid, and the rr pointer to return to 0 (requester 0 granted first after release).

Source files
------------

// File: rtl/gfau_pkg.sv
// Shared definitions for the GFAU arbiter: operation encoding, datapath width
// and the sequencer state encoding.
package gfau_pkg;

    localparam int SIZE = 33;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/gfau_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit at or above ptr,
// wrapping past N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            // One extra bit so ptr + k cannot overflow before the wrap for non power-of-two N.
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/gfau_arbiter.sv
// Round-robin sequencer sharing one GFAU between N_REQ requesters: accept one
// op, pulse start, hold operands, wait for done (or watchdog), return result.
module gfau_arbiter
    import gfau_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SIZE    = gfau_pkg::SIZE,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [2*N_REQ-1:0]    req_op,
    input  logic [SIZE*N_REQ-1:0] req_a,
    input  logic [SIZE*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [SIZE-1:0]       rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [SIZE-1:0]       gfau_in_0,
    output logic [SIZE-1:0]       gfau_in_1,
    output logic [1:0]            gfau_op,
    output logic                  gfau_start,
    input  logic [SIZE-1:0]       gfau_result,
    input  logic                  gfau_done,
    output state_t                dbg_state
);

    localparam int IW = $clog2(N_REQ);

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pick_idx;
    logic [N_REQ-1:0] grant;
    logic            pick_any;
    logic [1:0]      op_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] res_q;
    logic            err_q;
    logic [TW-1:0]   wd;
    logic [TW-1:0]   wd_inc;
    logic            wd_hit;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Watchdog counts WAIT cycles including the current one, so the abort
    // lands on the TIMEOUT-th WAIT cycle and RESP follows TIMEOUT+1 cycles after start.
    assign wd_inc = wd + 1'b1;
    assign wd_hit = (wd_inc == TW'(TIMEOUT));

    // Handshake: a transfer happens on a rising edge where req_valid[i] and
    // req_ready[i] are both high; ready is only offered in IDLE, to one requester,
    // and never depends on anything but req_valid and the rr pointer.
    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        gfau_start = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (pick_any) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gfau_start = 1'b1;
                state_nx   = ST_WAIT;
            end
            ST_WAIT: begin
                if (gfau_done || wd_hit) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[owner] = 1'b1;
                rsp_data         = res_q;
                rsp_err          = err_q;
                state_nx         = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            wd     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        op_q  <= req_op[int'(pick_idx)*2 +: 2];
                        a_q   <= req_a[int'(pick_idx)*SIZE +: SIZE];
                        b_q   <= req_b[int'(pick_idx)*SIZE +: SIZE];
                        res_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    wd <= '0;
                end
                ST_WAIT: begin
                    wd <= wd_inc;
                    // done has priority over a coincident watchdog expiry
                    if (gfau_done) begin
                        res_q <= gfau_result;
                        err_q <= 1'b0;
                    end else if (wd_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operands come only from the latched copies, so they cannot move while
    // the multiplier is scanning bits; zero when idle.
    assign busy      = (state != ST_IDLE);
    assign gfau_in_0 = busy ? a_q  : '0;
    assign gfau_in_1 = busy ? b_q  : '0;
    assign gfau_op   = busy ? op_q : '0;
    assign dbg_state = state;

endmodule
